// File: rtl/wheel_encoder_bank_pkg.sv
// wheel_encoder_bank_pkg: shared types and the 4x quadrature decode helper for the wheel encoder bank.
package wheel_encoder_bank_pkg;

    localparam int ENC_SYNC_STAGES = 2;

    typedef logic signed [1:0] enc_delta_t;

    typedef struct packed {
        enc_delta_t delta;
        logic       illegal;
    } quad_res_t;

    // {A,B} forward order is 00->10->11->01; A_prev ^ B_cur is high only when stepping in reverse.
    function automatic quad_res_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        quad_res_t  r;
        logic [1:0] diff;
        diff      = prev ^ cur;
        r.illegal = &diff;
        r.delta   = !(^diff) ? 2'sb00 : (prev[1] ^ cur[0]) ? 2'sb11 : 2'sb01;
        return r;
    endfunction

endpackage

// File: rtl/wheel_encoder_bank_enc_channel.sv
// wheel_encoder_bank_enc_channel: one encoder lane - synchronisers, 4x decode, wrapping position, saturating window accumulator.
// Index homing is compiled in only when WHEEL_ENC_INDEX_EN is defined.
module wheel_encoder_bank_enc_channel
    import wheel_encoder_bank_pkg::*;
#(
    parameter int POS_W = 32,
    parameter int VEL_W = 16
) (
    input  logic             sclk,
    input  logic             rstn,
    input  logic             a,
    input  logic             b,
    input  logic             i,
    input  logic             clr,
    input  logic             window_tick,
    output logic [POS_W-1:0] pos,
    output logic [VEL_W-1:0] vel,
    output logic             err,
    output logic             index_seen
);

    logic [ENC_SYNC_STAGES-1:0] sync_a, sync_b;
    logic [1:0]                 prev_ab, cur_ab;
    quad_res_t                  dec;
    logic [VEL_W-1:0]           acc, acc_next;
    logic [VEL_W:0]             acc_sum;
    logic                       home;

    assign cur_ab = {sync_a[ENC_SYNC_STAGES-1], sync_b[ENC_SYNC_STAGES-1]};
    assign dec    = quad_decode(prev_ab, cur_ab);

    // One guard bit detects signed overflow; clamp toward the sign of the true sum.
    always_comb begin
        acc_sum  = {acc[VEL_W-1], acc} + {{(VEL_W-1){dec.delta[1]}}, dec.delta};
        acc_next = (acc_sum[VEL_W] ^ acc_sum[VEL_W-1]) ?
                   {acc_sum[VEL_W], {(VEL_W-1){~acc_sum[VEL_W]}}} : acc_sum[VEL_W-1:0];
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sync_a  <= '0;
            sync_b  <= '0;
            prev_ab <= '0;
        end else begin
            sync_a  <= {sync_a[ENC_SYNC_STAGES-2:0], a};
            sync_b  <= {sync_b[ENC_SYNC_STAGES-2:0], b};
            prev_ab <= cur_ab;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            pos <= '0;
            err <= 1'b0;
        end else if (clr) begin
            pos <= '0;
            err <= 1'b0;
        end else begin
            pos <= home ? '0 : pos + {{(POS_W-2){dec.delta[1]}}, dec.delta};
            err <= err | dec.illegal;
        end
    end

    // The terminal-cycle delta belongs to the closing window, so the new window starts from zero.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
            vel <= '0;
        end else if (window_tick) begin
            acc <= '0;
            vel <= acc_next;
        end else begin
            acc <= acc_next;
        end
    end

`ifdef WHEEL_ENC_INDEX_EN
    logic [ENC_SYNC_STAGES-1:0] sync_i;
    logic                       prev_i;

    assign home = sync_i[ENC_SYNC_STAGES-1] & ~prev_i;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sync_i     <= '0;
            prev_i     <= 1'b0;
            index_seen <= 1'b0;
        end else begin
            sync_i     <= {sync_i[ENC_SYNC_STAGES-2:0], i};
            prev_i     <= sync_i[ENC_SYNC_STAGES-1];
            index_seen <= !clr & (index_seen | home);
        end
    end
`else
    logic unused_i;

    assign unused_i   = i;
    assign home       = 1'b0;
    assign index_seen = 1'b0;
`endif

endmodule

// File: rtl/wheel_encoder_bank.sv
// wheel_encoder_bank: NUM_ENC quadrature encoder lanes sharing one velocity sample window.
// Define WHEEL_ENC_INDEX_EN to enable index homing on enc_i.
module wheel_encoder_bank
    import wheel_encoder_bank_pkg::*;
#(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int NUM_ENC     = 4,
    parameter int POS_W       = 32,
    parameter int VEL_W       = 16,
    parameter int SAMPLE_HZ   = 1000
) (
    input  logic                     sclk,
    input  logic                     rstn,
    input  logic [NUM_ENC-1:0]       enc_a,
    input  logic [NUM_ENC-1:0]       enc_b,
    input  logic [NUM_ENC-1:0]       enc_i,
    input  logic [NUM_ENC-1:0]       clr,
    output logic [NUM_ENC*POS_W-1:0] pos_out,
    output logic [NUM_ENC*VEL_W-1:0] vel_out,
    output logic                     sample_valid,
    output logic [NUM_ENC-1:0]       err,
    output logic [NUM_ENC-1:0]       index_seen
);

    localparam int WINDOW = SYSCLK_FREQ / SAMPLE_HZ;
    localparam int CNT_W  = WINDOW > 1 ? $clog2(WINDOW) : 1;

    logic [CNT_W-1:0] win_cnt;
    logic             window_tick;

    assign window_tick = win_cnt == CNT_W'(WINDOW - 1);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            win_cnt      <= '0;
            sample_valid <= 1'b0;
        end else begin
            win_cnt      <= window_tick ? '0 : win_cnt + CNT_W'(1);
            sample_valid <= window_tick;
        end
    end

    for (genvar c = 0; c < NUM_ENC; c++) begin : g_ch
        wheel_encoder_bank_enc_channel #(
            .POS_W(POS_W),
            .VEL_W(VEL_W)
        ) u_ch (
            .sclk       (sclk),
            .rstn       (rstn),
            .a          (enc_a[c]),
            .b          (enc_b[c]),
            .i          (enc_i[c]),
            .clr        (clr[c]),
            .window_tick(window_tick),
            .pos        (pos_out[c*POS_W +: POS_W]),
            .vel        (vel_out[c*VEL_W +: VEL_W]),
            .err        (err[c]),
            .index_seen (index_seen[c])
        );
    end

endmodule

// File: tb/tb_wheel_encoder_bank.sv
// tb_wheel_encoder_bank: directed scenarios plus random motion, checked every cycle against a phase-arithmetic reference model.
module tb_wheel_encoder_bank;

    localparam int NE   = 4;
    localparam int PW   = 32;
    localparam int VW   = 8;
    localparam int FCLK = 4_000_000;
    localparam int SHZ  = 1000;
    localparam int W    = FCLK / SHZ;
    localparam int VMAX = 2 ** (VW - 1) - 1;
    localparam int VMIN = -(2 ** (VW - 1));
`ifdef WHEEL_ENC_INDEX_EN
    localparam bit IDX = 1'b1;
`else
    localparam bit IDX = 1'b0;
`endif

    logic             sclk = 1'b0;
    logic             rstn = 1'b0;
    logic [NE-1:0]    enc_a = '0, enc_b = '0, enc_i = '0, clr = '0;
    logic [NE*PW-1:0] pos_out;
    logic [NE*VW-1:0] vel_out;
    logic             sample_valid;
    logic [NE-1:0]    err, index_seen;

    wheel_encoder_bank #(
        .SYSCLK_FREQ(FCLK),
        .NUM_ENC    (NE),
        .POS_W      (PW),
        .VEL_W      (VW),
        .SAMPLE_HZ  (SHZ)
    ) dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .enc_i       (enc_i),
        .clr         (clr),
        .pos_out     (pos_out),
        .vel_out     (vel_out),
        .sample_valid(sample_valid),
        .err         (err),
        .index_seen  (index_seen)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    // Physical encoder phase per lane, plus the model's view of the world.
    int          ph[NE];
    int          cd[NE];
    int          e;
    logic [1:0]  ha[NE][4];
    logic        hi[NE][4];
    logic [PW-1:0] pos_m[NE];
    int          acc_m[NE], vel_m[NE];
    logic        err_m[NE], seen_m[NE];
    logic        sv_m;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int clampv(input int v);
        return v > VMAX ? VMAX : (v < VMIN ? VMIN : v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NE; c++) begin
            for (int k = 0; k < 4; k++) begin
                ha[c][k] = 2'b00;
                hi[c][k] = 1'b0;
            end
            pos_m[c]  = '0;
            acc_m[c]  = 0;
            vel_m[c]  = 0;
            err_m[c]  = 1'b0;
            seen_m[c] = 1'b0;
        end
        sv_m = 1'b0;
        e    = 0;
    endtask

    // Pin values reach the decoder two edges after capture and are compared with the value one edge older.
    task automatic model_edge();
        if (!rstn) begin
            model_reset();
            return;
        end
        e++;
        sv_m = (e % W) == 0;
        for (int c = 0; c < NE; c++) begin
            int  st, d, s;
            bit  rise;
            for (int k = 3; k > 0; k--) begin
                ha[c][k] = ha[c][k-1];
                hi[c][k] = hi[c][k-1];
            end
            ha[c][0] = {enc_a[c], enc_b[c]};
            hi[c][0] = enc_i[c];
            st   = (phase_of(ha[c][2]) - phase_of(ha[c][3]) + 4) % 4;
            d    = st == 1 ? 1 : (st == 3 ? -1 : 0);
            rise = IDX && hi[c][2] && !hi[c][3];
            if (clr[c]) begin
                pos_m[c]  = '0;
                err_m[c]  = 1'b0;
                seen_m[c] = 1'b0;
            end else begin
                if (rise) begin
                    pos_m[c]  = '0;
                    seen_m[c] = 1'b1;
                end else begin
                    pos_m[c] = pos_m[c] + PW'(d);
                end
                if (st == 2) err_m[c] = 1'b1;
            end
            s = clampv(acc_m[c] + d);
            if (sv_m) begin
                vel_m[c] = s;
                acc_m[c] = 0;
            end else begin
                acc_m[c] = s;
            end
        end
    endtask

    task automatic compare_all();
        logic [NE*PW-1:0] pe;
        logic [NE*VW-1:0] ve;
        logic [NE-1:0]    ee, se;
        for (int c = 0; c < NE; c++) begin
            pe[c*PW +: PW] = pos_m[c];
            ve[c*VW +: VW] = VW'(vel_m[c]);
            ee[c]          = err_m[c];
            se[c]          = seen_m[c];
        end
        check("pos", pos_out, pe);
        check("vel", vel_out, ve);
        check("sv", sample_valid, sv_m);
        check("err", err, ee);
        check("seen", index_seen, se);
    endtask

    task automatic cyc();
        @(posedge sclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive();
        for (int c = 0; c < NE; c++) begin
            logic [1:0] ab;
            ab       = ab_of(ph[c]);
            enc_a[c] = ab[1];
            enc_b[c] = ab[0];
        end
    endtask

    task automatic step(input int c, input int dir);
        ph[c] += dir;
        drive();
        repeat (3) cyc();
    endtask

    task automatic wait_sv();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!sample_valid && n < 2 * W);
        check("sv_wait", sample_valid, 1'b1);
    endtask

    function automatic logic [PW-1:0] plane(input int c);
        return pos_out[c*PW +: PW];
    endfunction

    function automatic logic [VW-1:0] vlane(input int c);
        return vel_out[c*VW +: VW];
    endfunction

    initial begin
        int n;
        for (int c = 0; c < NE; c++) begin
            ph[c] = 0;
            cd[c] = 0;
        end
        model_reset();
        drive();
        repeat (3) cyc();
        check("rst_pos", pos_out, '0);
        check("rst_vel", vel_out, '0);
        check("rst_sv", sample_valid, 1'b0);
        check("rst_err", err, '0);
        check("rst_seen", index_seen, '0);
        rstn = 1'b1;

        // Forward run on ch0 saturates the 8-bit velocity; reverse wrap on ch1.
        for (int k = 0; k < 1000; k++) step(0, 1);
        check("fwd_pos0", plane(0), 32'd1000);
        check("fwd_pos1_idle", plane(1), 32'd0);
        for (int k = 0; k < 3; k++) step(1, -1);
        check("rev_pos1", plane(1), 32'hFFFF_FFFD);
        wait_sv();
        check("sat_vel0", vlane(0), 8'd127);
        check("rev_vel1", vlane(1), 8'hFD);
        check("idle_vel2", vlane(2), 8'd0);
        check("idle_vel3", vlane(3), 8'd0);
        wait_sv();
        check("still_vel0", vlane(0), 8'd0);
        check("still_vel1", vlane(1), 8'd0);

        // Illegal double-bit change on ch2, then clear.
        for (int k = 0; k < 5; k++) step(2, 1);
        ph[2] += 2;
        drive();
        repeat (3) cyc();
        check("ill_err2", err[2], 1'b1);
        check("ill_pos2", plane(2), 32'd5);
        repeat (20) cyc();
        check("ill_sticky2", err[2], 1'b1);
        clr[2] = 1'b1;
        cyc();
        clr[2] = 1'b0;
        check("clr_err2", err[2], 1'b0);
        check("clr_pos2", plane(2), 32'd0);

        // Index pulse on ch3 at position 500.
        for (int k = 0; k < 500; k++) step(3, 1);
        check("home_pre3", plane(3), 32'd500);
        enc_i[3] = 1'b1;
        repeat (3) cyc();
        check("home_pos3", plane(3), IDX ? 32'd0 : 32'd500);
        check("home_seen3", index_seen[3], IDX);
        enc_i[3] = 1'b0;
        repeat (3) cyc();

        // ch0 step lands on the terminal cycle; ch1 step one cycle later falls into the next window.
        wait_sv();
        while ((e % W) != W - 3) cyc();
        ph[0] += 1;
        drive();
        cyc();
        ph[1] += 1;
        drive();
        cyc();
        cyc();
        check("edge_sv", sample_valid, 1'b1);
        check("edge_vel0", vlane(0), 8'd1);
        check("edge_vel1", vlane(1), 8'd0);
        wait_sv();
        check("next_vel0", vlane(0), 8'd0);
        check("next_vel1", vlane(1), 8'd1);

        // Asynchronous reset in the middle of a window.
        repeat (1234) cyc();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_pos", pos_out, '0);
        check("mid_rst_vel", vel_out, '0);
        check("mid_rst_sv", sample_valid, 1'b0);
        check("mid_rst_err", err, '0);
        check("mid_rst_seen", index_seen, '0);
        model_reset();
        for (int c = 0; c < NE; c++) ph[c] = 0;
        enc_i = '0;
        drive();
        repeat (2) cyc();
        rstn = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!sample_valid && n < 2 * W);
        check("rst_period", 128'(n), 128'(W));

        // Random motion, illegal jumps, index toggles and clears on all lanes.
        for (int t = 0; t < 8000; t++) begin
            for (int c = 0; c < NE; c++) begin
                int r;
                clr[c] = $urandom_range(0, 299) == 0;
                if (cd[c] > 0) begin
                    cd[c]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 15);
                    ph[c] += (r == 0) ? 2 : (r < 8 ? 1 : -1);
                    cd[c] = 2;
                end
                if ($urandom_range(0, 99) == 0) enc_i[c] = ~enc_i[c];
            end
            drive();
            cyc();
        end
        clr = '0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wheel_encoder_bank.md
# wheel_encoder_bank

Parametrised multi-channel quadrature encoder front end: the next generation of the rover's wheel encoder block, generalised from a fixed four-wheel interface to NUM_ENC channels. Each channel synchronises A/B/I, decodes 4x quadrature into a signed wrapping position, and accumulates a signed velocity over a fixed sample window. It flags illegal transitions and supports index homing. Sits under the rover top level on the 100 MHz system clock; its outputs feed CPUComms.

## Interface
- SYSCLK_FREQ, 100_000_000, system clock frequency in Hz
- NUM_ENC, 4, number of encoder channels (1..16)
- POS_W, 32, position counter width, signed two's complement
- VEL_W, 16, velocity (counts per window) width, signed
- SAMPLE_HZ, 1000, velocity sample rate; window = SYSCLK_FREQ/SAMPLE_HZ cycles (must divide exactly)

- sclk  in  1  system clock; single clock domain
- rstn  in  1  asynchronous active-low reset
- enc_a  in  NUM_ENC  channel A, asynchronous to sclk
- enc_b  in  NUM_ENC  channel B, asynchronous to sclk
- enc_i  in  NUM_ENC  index pulse, asynchronous to sclk
- clr  in  NUM_ENC  per-channel synchronous clear of position, err and index_seen
- pos_out  out  NUM_ENC*POS_W  live position, channel i at [i*POS_W +: POS_W]
- vel_out  out  NUM_ENC*VEL_W  last completed window count, channel i at [i*VEL_W +: VEL_W]
- sample_valid  out  1  one-cycle pulse when all vel_out lanes update together
- err  out  NUM_ENC  sticky illegal-transition flag
- index_seen  out  NUM_ENC  sticky index-detected flag

## Operation
- Reset: all synchronisers, pos_out, vel_out, accumulators, window counter, sample_valid, err, index_seen = 0. Previous-state registers also reset to 0.
- Synchronisation: each of A, B, I goes through two flops; decode uses the second flop (cur) against a third-stage register (prev).
- Decode on state {A,B}:
  - Forward sequence 00→10→11→01→00 gives delta +1.
  - Reverse sequence gives delta −1.
  - No change gives 0.
  - Both bits changing in one cycle gives delta 0 and sets err[i].
- Position: pos += delta, modulo 2^POS_W (wraps, no saturation).
- Velocity accumulator: acc += delta, saturating at the VEL_W signed limits (+2^(VEL_W−1)−1 / −2^(VEL_W−1)).
- Window: a shared counter runs 0..WINDOW−1. On the terminal cycle:
  - vel_out[i] takes acc[i] plus that cycle's delta, saturated.
  - acc[i] restarts at 0.
  - sample_valid = 1 for that one cycle.
- clr[i]: the next cycle gives pos=0, err=0, index_seen=0. clr wins over a simultaneous count or index. It does not touch acc or vel_out.
- Channels are fully independent; only the window counter is shared.

## Timing
- Pin edge to pos_out change: 3 sclk cycles (2 sync plus 1 register).
- sample_valid period: exactly WINDOW cycles. The first pulse comes WINDOW cycles after rstn deasserts.
- Velocity sees the same 3-cycle input latency; an edge is credited to the window in which its decoded delta lands.
- Simultaneous delta and terminal count: the delta goes into vel_out, not into the new acc.
- Reset asserted mid-window: everything returns to reset values immediately (async). The window restarts on deassert.
- Max input edge rate: one state change per 3 sclk cycles per channel. Faster changes may alias into err.

## Configuration
- WHEEL_ENC_INDEX_EN defined:
  - A rising edge on the synchronised I (cur=1, prev=0) sets pos[i]=0 and sets index_seen[i].
  - The same-cycle quadrature delta is discarded for position but still counted in acc.
  - clr has priority over index.
- Not defined: enc_i is ignored, with no synchroniser instantiated. index_seen is tied to 0.

## Structure
- roversPackage gets three additions:
  - typedef enc_delta_t: a 2-bit signed delta.
  - Function quad_decode(prev, cur) returning the delta and an illegal flag.
  - Constant ENC_SYNC_STAGES = 2.
- One sub-module, enc_channel, is generated NUM_ENC times:
  - Contains the synchronisers, decode, position, accumulator, err and index logic for one channel.
  - Takes the shared window_tick.
- The top holds the window counter and packs the output buses.

## Test plan
- **Forward motion:** ch0 driven with 1000 forward steps, edges 10 cycles apart, within one window → pos_out[0]=1000, next vel_out[0]=1000, other channels stay 0.
- **Reverse wrap:** from reset, 3 reverse steps on ch1 with POS_W=32 → pos_out[1]=32'hFFFF_FFFD; vel_out[1]=−3 after the window.
- **Illegal transition:** A and B toggled in the same cycle on ch2 → pos unchanged, err[2]=1 and stays set. Then clr[2] pulsed → err[2]=0, pos=0.
- **Velocity saturation:** with VEL_W=8, 300 forward steps in one window → vel_out=127; the next window with no motion → vel_out=0.
- **Index homing:** with WHEEL_ENC_INDEX_EN, ch3 at pos=500 and an I pulse → pos_out[3]=0 three cycles after the I rising edge, index_seen[3]=1. Same stimulus without the macro → pos stays 500, index_seen=0.
- **Window boundary and reset:** a step landing exactly on the terminal cycle is counted in that vel_out. rstn pulsed mid-window → all outputs 0, and the next sample_valid comes WINDOW cycles after release.
